video_mode_sched: RTL
=====================

VIDEO_MODE_SCHED -- requirements
Module: video_mode_sched

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 16: number of cycles gen_reset is held per mode load.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 2000000: maximum wait for a vs_in rising edge before a forced switch.
REQ-003 SHALL have port clk_in  input  1  pixel clock; single clock domain.
REQ-004 SHALL have port reset_n  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port mode_req  input  1  one-cycle request strobe.
REQ-006 SHALL have port mode_sel  input  2  requested mode: 0=720p, 1=1080p, 2=1080i, 3=reserved; sampled with mode_req.
REQ-007 SHALL have port vs_in  input  1  active-high vsync from the sync generator.
REQ-008 SHALL have port gen_reset  output  1  active-high reset to the sync and pattern generators.
REQ-009 SHALL have port timing  output  180  packed timing word, 15 fields of 12 bits.
REQ-010 SHALL have port interlaced  output  1  interlaced flag for the current mode.
REQ-011 SHALL have port ramp_step  output  20  pattern ramp step.
REQ-012 SHALL have port cur_mode  output  2  mode currently loaded.
REQ-013 SHALL have port mode_busy, mode_ack, mode_err, timeout_flag  outputs  1 each  handshake and status.

Function
REQ-014 timing field order, LSB first: h_total, h_fp, h_bp, h_sync, v_total_0, v_fp_0, v_bp_0, v_sync_0, v_total_1, v_fp_1, v_bp_1, v_sync_1, hv_offset_1, active_pix, active_lines.
REQ-015 Mode 0 SHALL load 1650,110,220,40,750,5,20,5,0,0,0,0,0,1280,720; interlaced=0; ramp_step=0x00333.
REQ-016 Mode 1 SHALL load 2200,88,148,44,1125,4,36,5,0,0,0,0,0,1920,1080; interlaced=0; ramp_step=0x00222.
REQ-017 Mode 2 SHALL load 2200,88,148,44,562,2,15,5,563,2,16,5,1100,1920,1080; interlaced=1; ramp_step=0x00222.
REQ-018 FSM states SHALL be IDLE, WAIT_VS, HOLD and DONE; mode_busy=1 in every state except IDLE.
REQ-019 IDLE: a valid mode_req whose mode_sel differs from cur_mode SHALL latch mode_sel and go to WAIT_VS on the next cycle.
REQ-020 IDLE: a valid mode_req whose mode_sel equals cur_mode SHALL pulse mode_ack for one cycle, exactly one cycle after the request, without asserting gen_reset.
REQ-021 mode_sel=3 (or any disabled mode, see REQ-031) SHALL pulse mode_err for one cycle after the request; all state and outputs stay unchanged.
REQ-022 mode_req SHALL be ignored while mode_busy=1; no ack and no err are produced.
REQ-023 WAIT_VS: a vs_in rising edge, detected with a one-register delay, SHALL move the FSM to HOLD.
REQ-024 WAIT_VS: if TIMEOUT_CYCLES cycles elapse with no vs_in edge, the FSM SHALL enter HOLD anyway and set timeout_flag.
REQ-025 timeout_flag SHALL be sticky until the next accepted request, which clears it.
REQ-026 HOLD: on entry, gen_reset=1 and timing, interlaced, ramp_step and cur_mode update in the same cycle.
REQ-027 HOLD SHALL last exactly HOLD_CYCLES cycles, then go to DONE.
REQ-028 DONE SHALL last one cycle: gen_reset=0, mode_ack=1, then return to IDLE.
REQ-029 Outputs SHALL be registered; timing SHALL never change except on HOLD entry.

Reset
REQ-030 On reset_n=0: cur_mode=0 with mode 0 values loaded, gen_reset=1, FSM=HOLD with counter=0, mode_ack=0, mode_err=0, timeout_flag=0, mode_busy=1. After release, the block runs HOLD to DONE to IDLE and pulses mode_ack once. Reset mid-switch SHALL abandon the pending mode.

Configuration
REQ-031 Macro VIDEO_MODE_1080I_EN: when defined, mode 2 is supported. When undefined, mode_sel=2 is treated as reserved (mode_err), the mode 2 table is removed, and interlaced is tied to 0.

Verification
REQ-032 Release reset -> gen_reset high for 16 cycles, one mode_ack pulse, cur_mode=0, timing h_total field=1650.
REQ-033 mode_req with mode_sel=1, vs_in edge 100 cycles later -> gen_reset rises 1 cycle after the edge and holds 16 cycles; h_total=2200, active_lines=1080, then mode_ack.
REQ-034 mode_req with mode_sel=1, vs_in held low, TIMEOUT_CYCLES=1000 -> HOLD entered after 1000 cycles, timeout_flag=1; the next request clears it.
REQ-035 mode_req with mode_sel=3 -> one-cycle mode_err, timing unchanged. mode_req with mode_sel=cur_mode -> mode_ack 1 cycle later, gen_reset stays 0.
REQ-036 mode_req during HOLD -> ignored. reset_n low during WAIT_VS -> mode 0 restored and the power-up sequence repeats.
REQ-037 Build without VIDEO_MODE_1080I_EN, mode_req with mode_sel=2 -> mode_err, interlaced stays 0.

Source files
------------

// File: rtl/video_mode_sched.sv
// Video mode scheduler: loads a mode's timing table into the sync/pattern generators,
// switching at a vsync edge (or timeout). Define VIDEO_MODE_1080I_EN to enable mode 2 (1080i).
module video_mode_sched #(
  parameter int HOLD_CYCLES    = 16,
  parameter int TIMEOUT_CYCLES = 2000000
) (
  input  logic         clk_in,
  input  logic         reset_n,
  input  logic         mode_req,
  input  logic [1:0]   mode_sel,
  input  logic         vs_in,
  output logic         gen_reset,
  output logic [179:0] timing,
  output logic         interlaced,
  output logic [19:0]  ramp_step,
  output logic [1:0]   cur_mode,
  output logic         mode_busy,
  output logic         mode_ack,
  output logic         mode_err,
  output logic         timeout_flag
);

  localparam int CNT_MAX = (TIMEOUT_CYCLES > HOLD_CYCLES) ? TIMEOUT_CYCLES : HOLD_CYCLES;
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  typedef enum logic [1:0] {IDLE, WAIT_VS, HOLD, DONE} state_t;

  // Fields packed MSB first: active_lines ... h_total.
  function automatic logic [179:0] mode_timing(input logic [1:0] m);
    case (m)
      2'd1: return {12'd1080, 12'd1920, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0,
                    12'd5, 12'd36, 12'd4, 12'd1125, 12'd44, 12'd148, 12'd88, 12'd2200};
`ifdef VIDEO_MODE_1080I_EN
      2'd2: return {12'd1080, 12'd1920, 12'd1100, 12'd5, 12'd16, 12'd2, 12'd563,
                    12'd5, 12'd15, 12'd2, 12'd562, 12'd44, 12'd148, 12'd88, 12'd2200};
`endif
      default: return {12'd720, 12'd1280, 12'd0, 12'd0, 12'd0, 12'd0, 12'd0,
                       12'd5, 12'd20, 12'd5, 12'd750, 12'd40, 12'd220, 12'd110, 12'd1650};
    endcase
  endfunction

  function automatic logic [19:0] mode_ramp(input logic [1:0] m);
    return (m == 2'd0) ? 20'h00333 : 20'h00222;
  endfunction

  function automatic logic mode_ok(input logic [1:0] m);
`ifdef VIDEO_MODE_1080I_EN
    return (m != 2'd3);
`else
    return (m == 2'd0) || (m == 2'd1);
`endif
  endfunction

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [1:0]         pend_q, pend_d;
  logic               vs_q;
  logic               gen_reset_q, gen_reset_d;
  logic [179:0]       timing_q, timing_d;
  logic [19:0]        ramp_q, ramp_d;
  logic [1:0]         cur_mode_q, cur_mode_d;
  logic               busy_q, busy_d;
  logic               ack_q, ack_d;
  logic               err_q, err_d;
  logic               tflag_q, tflag_d;
  logic               load;
  logic               vs_rise;

  assign vs_rise = vs_in & ~vs_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pend_d     = pend_q;
    timing_d   = timing_q;
    ramp_d     = ramp_q;
    cur_mode_d = cur_mode_q;
    tflag_d    = tflag_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    load       = 1'b0;
    case (state_q)
      IDLE: begin
        if (mode_req) begin
          if (!mode_ok(mode_sel)) begin
            err_d = 1'b1;
          end else begin
            tflag_d = 1'b0;
            if (mode_sel == cur_mode_q) begin
              ack_d = 1'b1;
            end else begin
              pend_d  = mode_sel;
              cnt_d   = '0;
              state_d = WAIT_VS;
            end
          end
        end
      end
      WAIT_VS: begin
        if (vs_rise) begin
          load = 1'b1;
        end else if (cnt_q == CNT_W'(TIMEOUT_CYCLES - 1)) begin
          load    = 1'b1;
          tflag_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      HOLD: begin
        if (cnt_q == CNT_W'(HOLD_CYCLES - 1)) begin
          state_d = DONE;
          ack_d   = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
    // The only place the generator-facing tables may change.
    if (load) begin
      state_d    = HOLD;
      cnt_d      = '0;
      timing_d   = mode_timing(pend_q);
      ramp_d     = mode_ramp(pend_q);
      cur_mode_d = pend_q;
    end
    gen_reset_d = (state_d == HOLD);
    busy_d      = (state_d != IDLE);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= HOLD;
      cnt_q       <= '0;
      pend_q      <= 2'd0;
      vs_q        <= 1'b0;
      gen_reset_q <= 1'b1;
      timing_q    <= mode_timing(2'd0);
      ramp_q      <= mode_ramp(2'd0);
      cur_mode_q  <= 2'd0;
      busy_q      <= 1'b1;
      ack_q       <= 1'b0;
      err_q       <= 1'b0;
      tflag_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      pend_q      <= pend_d;
      vs_q        <= vs_in;
      gen_reset_q <= gen_reset_d;
      timing_q    <= timing_d;
      ramp_q      <= ramp_d;
      cur_mode_q  <= cur_mode_d;
      busy_q      <= busy_d;
      ack_q       <= ack_d;
      err_q       <= err_d;
      tflag_q     <= tflag_d;
    end
  end

`ifdef VIDEO_MODE_1080I_EN
  logic interlaced_q, interlaced_d;

  always_comb begin
    interlaced_d = interlaced_q;
    if (load) interlaced_d = (pend_q == 2'd2);
  end

  always_ff @(posedge clk_in or negedge reset_n) begin
    if (!reset_n) interlaced_q <= 1'b0;
    else          interlaced_q <= interlaced_d;
  end

  assign interlaced = interlaced_q;
`else
  assign interlaced = 1'b0;
`endif

  assign gen_reset    = gen_reset_q;
  assign timing       = timing_q;
  assign ramp_step    = ramp_q;
  assign cur_mode     = cur_mode_q;
  assign mode_busy    = busy_q;
  assign mode_ack     = ack_q;
  assign mode_err     = err_q;
  assign timeout_flag = tflag_q;

endmodule
